// File: rtl/deser8.sv
// Serial-to-parallel byte assembler with in-band sync, one byte of output
// buffering and an overrun pulse when a finished byte cannot be stored.
module deser8 #(
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       in_sync,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun,
    output logic [2:0] bit_idx
);

    // state   | meaning
    // IDLE    | bit_idx = 0, no partial byte held
    // COLLECT | 1 to 7 bits of the current byte held
    typedef enum logic {IDLE, COLLECT} state_t;

    state_t     state, state_nx;
    logic [7:0] asm_q, asm_nx;
    logic [7:0] out_data_nx;
    logic [2:0] bit_idx_nx;
    logic [2:0] slot, pos;
    logic       out_valid_nx, overrun_nx, complete;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            asm_q     <= 8'h00;
            bit_idx   <= 3'd0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            asm_q     <= asm_nx;
            bit_idx   <= bit_idx_nx;
            out_data  <= out_data_nx;
            out_valid <= out_valid_nx;
            overrun   <= overrun_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        asm_nx       = asm_q;
        bit_idx_nx   = bit_idx;
        out_data_nx  = out_data;
        out_valid_nx = out_valid;
        overrun_nx   = 1'b0;
        complete     = 1'b0;
        slot         = (in_sync || state == IDLE) ? 3'd0 : bit_idx;
        pos          = (LSB_FIRST != 0) ? slot : (3'd7 - slot);

        if (in_valid) begin
            if (in_sync) begin
                // sync restarts the byte: drop whatever partial bits were held
                asm_nx      = 8'h00;
                asm_nx[pos] = in_bit;
                bit_idx_nx  = 3'd1;
                state_nx    = COLLECT;
            end else begin
                asm_nx[pos] = in_bit;
                bit_idx_nx  = bit_idx + 3'd1;
                if (bit_idx == 3'd7) begin
                    complete = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = COLLECT;
                end
            end
        end

        if (out_valid && out_ready)
            out_valid_nx = 1'b0;

        // a completion on a handshake edge refills the buffer in the same cycle
        if (complete) begin
            if (!out_valid || out_ready) begin
                out_data_nx  = asm_nx;
                out_valid_nx = 1'b1;
            end else begin
                overrun_nx = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_deser8.sv
// Scoreboard bench for deser8: LSB-first and MSB-first instances share one
// input stream; expected bytes are queued at the 8th bit and popped on handshake.
module tb_deser8;

    logic       clk, rst_n, in_valid, in_bit, in_sync, out_ready;
    logic [7:0] data_l, data_m;
    logic       valid_l, valid_m, ovr_l, ovr_m;
    logic [2:0] idx_l, idx_m;

    int checks = 0;
    int errors = 0;
    int ov_count = 0;
    logic [7:0] q_lsb[$];
    logic [7:0] q_msb[$];

    deser8 #(.LSB_FIRST(1)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .in_sync(in_sync), .out_data(data_l), .out_valid(valid_l),
        .out_ready(out_ready), .overrun(ovr_l), .bit_idx(idx_l)
    );

    deser8 #(.LSB_FIRST(0)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .in_sync(in_sync), .out_data(data_m), .out_valid(valid_m),
        .out_ready(out_ready), .overrun(ovr_m), .bit_idx(idx_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // handshake monitor: a byte is consumed on the next rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (valid_l !== valid_m || ovr_l !== ovr_m || idx_l !== idx_m) begin
                errors++;
                $display("FAIL inst_agree: lsb v=%b o=%b i=%0d msb v=%b o=%b i=%0d",
                         valid_l, ovr_l, idx_l, valid_m, ovr_m, idx_m);
            end
            if (ovr_l === 1'b1) ov_count++;
            if (valid_l === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (q_lsb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_byte: got %h, none expected", data_l);
                end else begin
                    logic [7:0] el, em;
                    el = q_lsb.pop_front();
                    em = q_msb.pop_front();
                    if (data_l !== el || data_m !== em) begin
                        errors++;
                        $display("FAIL sb_byte: lsb got %h want %h, msb got %h want %h",
                                 data_l, el, data_m, em);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sync, input logic keep);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_bit   = b[i];
            in_sync  = (i == 0) ? sync : 1'b0;
            if (i == 7 && keep) begin
                q_lsb.push_back(b);
                q_msb.push_back(rev8(b));
            end
            step();
        end
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_sync = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if ({data_l, valid_l, ovr_l, idx_l} !== 13'd0 || data_m !== 8'h00) begin
            errors++;
            $display("FAIL reset_vals: data %h/%h valid %b ovr %b idx %0d, want zeros",
                     data_l, data_m, valid_l, ovr_l, idx_l);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_byte(8'hAA, 1'b1, 1'b1);
        checks++;
        if (valid_l !== 1'b1 || data_l !== 8'hAA || data_m !== 8'h55 || idx_l !== 3'd0) begin
            errors++;
            $display("FAIL basic_byte: valid %b lsb %h msb %h idx %0d, want 1 aa 55 0",
                     valid_l, data_l, data_m, idx_l);
        end
        step();
        checks++;
        if (valid_l !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse: valid %b after one cycle, want 0", valid_l);
        end
    endtask

    task automatic test_overrun();
        int ov0;
        ov0 = ov_count;
        out_ready = 1'b0;
        send_byte(8'hAA, 1'b0, 1'b1);
        send_byte(8'h0F, 1'b0, 1'b0);
        checks++;
        if (ovr_l !== 1'b1 || data_l !== 8'hAA || valid_l !== 1'b1 || idx_l !== 3'd0) begin
            errors++;
            $display("FAIL ovr_drop: ovr %b data %h valid %b idx %0d, want 1 aa 1 0",
                     ovr_l, data_l, valid_l, idx_l);
        end
        step();
        checks++;
        if (ovr_l !== 1'b0 || data_l !== 8'hAA) begin
            errors++;
            $display("FAIL ovr_len: ovr %b data %h, want 0 aa", ovr_l, data_l);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (valid_l !== 1'b0 || ov_count - ov0 !== 1) begin
            errors++;
            $display("FAIL ovr_drain: valid %b pulses %0d, want 0 1", valid_l, ov_count - ov0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        out_ready = 1'b0;
        send_byte(8'h3C, 1'b0, 1'b1);
        b = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_bit   = b[i];
            if (i == 7) begin
                out_ready = 1'b1;
                q_lsb.push_back(b);
                q_msb.push_back(rev8(b));
            end
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (valid_l !== 1'b1 || data_l !== 8'hC3 || data_m !== 8'hC3 || ovr_l !== 1'b0) begin
            errors++;
            $display("FAIL b2b_load: valid %b data %h/%h ovr %b, want 1 c3/c3 0",
                     valid_l, data_l, data_m, ovr_l);
        end
        step();
        checks++;
        if (valid_l !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: valid %b, want 0", valid_l);
        end
    endtask

    task automatic test_resync();
        logic [7:0] b;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_bit = 1'b1; in_sync = 1'b0;
            step();
        end
        b = 8'h81;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_bit   = b[i];
            in_sync  = (i == 0);
            if (i == 7) begin
                q_lsb.push_back(b);
                q_msb.push_back(rev8(b));
            end
            step();
            if (i == 0) begin
                checks++;
                if (idx_l !== 3'd1) begin
                    errors++;
                    $display("FAIL resync_idx: idx %0d, want 1", idx_l);
                end
            end
            if (i < 7) begin
                checks++;
                if (valid_l !== 1'b0) begin
                    errors++;
                    $display("FAIL resync_spurious: valid %b at bit %0d, want 0", valid_l, i);
                end
            end
        end
        in_valid = 1'b0; in_sync = 1'b0;
        checks++;
        if (valid_l !== 1'b1 || data_l !== 8'h81) begin
            errors++;
            $display("FAIL resync_byte: valid %b data %h, want 1 81", valid_l, data_l);
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_byte(8'h5A, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_bit = 1'b1;
            step();
        end
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({data_l, valid_l, ovr_l, idx_l} !== 13'd0 || data_m !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: data %h/%h valid %b ovr %b idx %0d, want zeros",
                     data_l, data_m, valid_l, ovr_l, idx_l);
        end
        q_lsb.delete();
        q_msb.delete();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_byte(8'hA5, 1'b0, 1'b1);
        checks++;
        if (valid_l !== 1'b1 || data_l !== 8'hA5 || data_m !== 8'hA5) begin
            errors++;
            $display("FAIL reset_recover: valid %b data %h/%h, want 1 a5/a5",
                     valid_l, data_l, data_m);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_resync();
        test_reset_mid();
        step();
        checks++;
        if (q_lsb.size() != 0 || ov_count != 1) begin
            errors++;
            $display("FAIL final: %0d bytes unconsumed, %0d overruns, want 0 1",
                     q_lsb.size(), ov_count);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
